// File: rtl/phase_seq_pkg.sv
// Shared types and constants for the phase sequencer: FSM encoding, phase codes
// and config register addresses.
package phase_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } fsm_e;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;

  localparam logic [2:0] CFG_DWELL0 = 3'd0;
  localparam logic [2:0] CFG_DWELL1 = 3'd1;
  localparam logic [2:0] CFG_DWELL2 = 3'd2;
  localparam logic [2:0] CFG_DWELL3 = 3'd3;
  localparam logic [2:0] CFG_LOOPS  = 3'd4;

  // Addresses above the loops register have no backing storage.
  function automatic logic cfg_addr_valid(input logic [2:0] addr);
    return addr <= CFG_LOOPS;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Dwell down-counter: load has priority over hold; counting stops at zero and
// zero_o flags the last cycle of the current phase.
module phase_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         hold_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (!hold_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/phase_sequencer.sv
// Phase sequencer: walks phases 00..11 with programmable dwell, repeats the pass
// loops+1 times, and drives registered phase/enable/data to the datapath.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int unsigned DWELL_W  = 8,
  parameter logic [3:0]  DATA_MAP = 4'b0100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               abort,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_addr,
  input  logic [DWELL_W-1:0] cfg_wdata,
  output logic [1:0]         state,
  output logic               enable,
  output logic               data,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  fsm_e               fsm_q, fsm_d;
  logic [1:0]         phase_q, phase_d;
  logic [1:0]         phase_inc;
  logic [DWELL_W-1:0] loops_q;
  logic [DWELL_W-1:0] loops_left_q, loops_left_d;
  logic [DWELL_W-1:0] dwell_cfg [4];
  logic [DWELL_W-1:0] dwell_sh  [4];

  logic               capture;
  logic               tmr_load;
  logic               tmr_hold;
  logic               tmr_zero;
  logic [DWELL_W-1:0] tmr_val;
  logic               cfg_wr_ok;

  logic enable_q, enable_d;
  logic data_q, data_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic cfg_err_q, cfg_err_d;

  assign phase_inc = phase_q + 2'd1;
  assign cfg_wr_ok = cfg_we && (fsm_q == IDLE) && cfg_addr_valid(cfg_addr);

  // Host-visible dwell registers and the per-run shadow copies the timer reloads from.
  for (genvar gi = 0; gi < 4; gi++) begin : g_dwell
    logic [DWELL_W-1:0] cfg_q;
    logic [DWELL_W-1:0] sh_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        cfg_q <= '0;
        sh_q  <= '0;
      end else begin
        if (cfg_wr_ok && (cfg_addr == (CFG_DWELL0 + 3'(gi)))) begin
          cfg_q <= cfg_wdata;
        end
        if (capture) begin
          sh_q <= cfg_q;
        end
      end
    end

    assign dwell_cfg[gi] = cfg_q;
    assign dwell_sh[gi]  = sh_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loops_q <= '0;
    end else if (cfg_wr_ok && (cfg_addr == CFG_LOOPS)) begin
      loops_q <= cfg_wdata;
    end
  end

  phase_timer #(
    .W (DWELL_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .hold_i     (tmr_hold),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= IDLE;
      phase_q      <= PH_00;
      loops_left_q <= '0;
    end else begin
      fsm_q        <= fsm_d;
      phase_q      <= phase_d;
      loops_left_q <= loops_left_d;
    end
  end

  always_comb begin
    fsm_d        = fsm_q;
    phase_d      = phase_q;
    loops_left_d = loops_left_q;
    capture      = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = dwell_sh[0];
    tmr_hold     = 1'b1;
    case (fsm_q)
      IDLE: begin
        if (start && !abort) begin
          fsm_d        = RUN;
          phase_d      = PH_00;
          loops_left_d = loops_q;
          capture      = 1'b1;
          tmr_load     = 1'b1;
          tmr_val      = dwell_cfg[0];
        end
      end
      RUN: begin
        if (abort) begin
          fsm_d   = IDLE;
          phase_d = PH_00;
        end else begin
          // An enabled cycle always counts toward the dwell; pause only
          // redirects where the FSM goes next, so no cycle is lost or added.
          fsm_d = pause ? PAUSE : RUN;
          if (!tmr_zero) begin
            tmr_hold = 1'b0;
          end else if (phase_q != PH_11) begin
            phase_d  = phase_inc;
            tmr_load = 1'b1;
            tmr_val  = dwell_sh[phase_inc];
          end else if (loops_left_q != '0) begin
            loops_left_d = loops_left_q - DWELL_W'(1);
            phase_d      = PH_00;
            tmr_load     = 1'b1;
            tmr_val      = dwell_sh[0];
          end else begin
            fsm_d = DONE;
          end
        end
      end
      PAUSE: begin
        if (abort) begin
          fsm_d   = IDLE;
          phase_d = PH_00;
        end else if (!pause) begin
          fsm_d = RUN;
        end
      end
      DONE: begin
        fsm_d   = IDLE;
        phase_d = PH_00;
      end
      default: begin
        fsm_d   = IDLE;
        phase_d = PH_00;
      end
    endcase
  end

  // Outputs are decoded from next state so they line up with phase_q.
  always_comb begin
    enable_d  = (fsm_d == RUN);
    busy_d    = (fsm_d != IDLE);
    done_d    = (fsm_d == DONE);
    data_d    = (fsm_d != IDLE) && DATA_MAP[phase_d];
    cfg_err_d = cfg_we && !cfg_wr_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q  <= 1'b0;
      data_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      enable_q  <= enable_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign state   = phase_q;
  assign enable  = enable_q;
  assign data    = data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: inputs change 1 ns after a rising edge and
// outputs are sampled there, so "cycle n" is the n-th cycle after start is taken.
module tb_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, pause, abort, cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [1:0] state;
  logic       enable, data, busy, done, cfg_err;

  int checks = 0;
  int errors = 0;

  phase_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .abort     (abort),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .state     (state),
    .enable    (enable),
    .data      (data),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [7:0] val);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = val;
    tick();
    cfg_we = 1'b0;
    chk("cfg_write_no_err", cfg_err, 1'b0);
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      tick();
    end
    chk(tag, busy, 1'b0);
  endtask

  logic [1:0] exp_tr[$];
  int         dw2[4] = '{2, 0, 3, 1};
  logic       exp_en3 [14] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
  logic [1:0] exp_st3 [14] = '{0, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3, 3, 0};
  int         done_cnt, en_total, en_p2;

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_state", state, 2'b00);
    chk("rst_enable", enable, 1'b0);
    chk("rst_data", data, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);

    // start together with abort is not accepted
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 1'b0);
    chk("start_abort_en", enable, 1'b0);

    // default config: four 1-cycle phases
    start_run();
    chk("t1_c1_state", state, 2'b00); chk("t1_c1_en", enable, 1'b1);
    chk("t1_c1_data", data, 1'b0);    chk("t1_c1_busy", busy, 1'b1);
    tick();
    chk("t1_c2_state", state, 2'b01); chk("t1_c2_en", enable, 1'b1); chk("t1_c2_data", data, 1'b0);
    tick();
    chk("t1_c3_state", state, 2'b10); chk("t1_c3_en", enable, 1'b1); chk("t1_c3_data", data, 1'b1);
    tick();
    chk("t1_c4_state", state, 2'b11); chk("t1_c4_en", enable, 1'b1); chk("t1_c4_data", data, 1'b0);
    tick();
    chk("t1_c5_done", done, 1'b1);    chk("t1_c5_en", enable, 1'b0);
    chk("t1_c5_busy", busy, 1'b1);    chk("t1_c5_state", state, 2'b11);
    tick();
    chk("t1_c6_busy", busy, 1'b0);    chk("t1_c6_state", state, 2'b00);
    chk("t1_c6_done", done, 1'b0);

    // dwell 2,0,3,1 with loops=1: two passes of 3,1,4,2 cycles
    cfg_write(3'd0, 8'd2);
    cfg_write(3'd1, 8'd0);
    cfg_write(3'd2, 8'd3);
    cfg_write(3'd3, 8'd1);
    cfg_write(3'd4, 8'd1);
    for (int p = 0; p < 2; p++)
      for (int ph = 0; ph < 4; ph++)
        for (int k = 0; k <= dw2[ph]; k++)
          exp_tr.push_back(2'(ph));
    start_run();
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      chk("t2_state", state, exp_tr[i]);
      chk("t2_en", enable, 1'b1);
      if (done) done_cnt++;
      tick();
    end
    chk("t2_done", done, 1'b1);
    chk("t2_done_en", enable, 1'b0);
    if (done) done_cnt++;
    tick();
    chk("t2_idle_busy", busy, 1'b0);
    if (done) done_cnt++;
    chk("t2_done_count", 8'(done_cnt), 8'd1);

    // pause for 5 cycles at the start of phase 10 with dwell[2]=3
    cfg_write(3'd0, 8'd0);
    cfg_write(3'd3, 8'd0);
    cfg_write(3'd4, 8'd0);
    start_run();
    en_total = 0; en_p2 = 0;
    for (int c = 0; c < 14; c++) begin
      chk("t3_en", enable, exp_en3[c]);
      chk("t3_state", state, exp_st3[c]);
      if (enable) en_total++;
      if (enable && state == 2'b10) en_p2++;
      pause = (c >= 2 && c <= 6);
      tick();
    end
    pause = 1'b0;
    chk("t3_phase10_enabled", 8'(en_p2), 8'd4);
    chk("t3_total_enabled", 8'(en_total), 8'd7);

    // abort in phase 01
    start_run();
    chk("t4_c1_state", state, 2'b00);
    tick();
    chk("t4_c2_state", state, 2'b01);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_state", state, 2'b00);
    chk("t4_en", enable, 1'b0);
    chk("t4_busy", busy, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_cnt++;
      tick();
    end
    chk("t4_no_done", 8'(done_cnt), 8'd0);

    // rejected writes: while busy and to an invalid address
    start_run();
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 8'd5;
    tick();
    cfg_we = 1'b0;
    chk("t5_busy_err", cfg_err, 1'b1);
    tick();
    chk("t5_busy_err_clear", cfg_err, 1'b0);
    wait_idle("t5_run_end");
    cfg_we = 1'b1; cfg_addr = 3'd5; cfg_wdata = 8'd7;
    tick();
    cfg_we = 1'b0;
    chk("t5_addr_err", cfg_err, 1'b1);
    tick();
    chk("t5_addr_err_clear", cfg_err, 1'b0);
    start_run();
    chk("t5_c1_state", state, 2'b00);
    tick();
    chk("t5_dwell0_kept", state, 2'b01);
    wait_idle("t5_run2_end");

    // reset in the middle of phase 10 clears outputs and config
    start_run();
    tick();
    tick();
    chk("t6_c3_state", state, 2'b10);
    chk("t6_c3_data", data, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_state", state, 2'b00);
    chk("t6_rst_en", enable, 1'b0);
    chk("t6_rst_data", data, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", done, 1'b0);
    chk("t6_rst_cfg_err", cfg_err, 1'b0);
    start_run();
    tick();
    tick();
    chk("t6_post_c3_state", state, 2'b10);
    tick();
    chk("t6_post_c4_state", state, 2'b11);
    tick();
    chk("t6_post_c5_done", done, 1'b1);
    tick();
    chk("t6_post_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
